// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // March element index, 0..5.
  typedef logic [2:0] elem_t;

  localparam elem_t E0 = 3'd0;
  localparam elem_t E1 = 3'd1;
  localparam elem_t E2 = 3'd2;
  localparam elem_t E3 = 3'd3;
  localparam elem_t E4 = 3'd4;
  localparam elem_t E5 = 3'd5;

  // Element tables: bit i describes element Ei.
  //   E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 dn r0,w1 | E4 dn r1,w0 | E5 up r0
  localparam logic [5:0] ELEM_DOWN   = 6'b01_1000;  // descending address order
  localparam logic [5:0] ELEM_HAS_RD = 6'b11_1110;  // element starts with a read
  localparam logic [5:0] ELEM_HAS_WR = 6'b01_1111;  // element ends with a write
  localparam logic [5:0] ELEM_RD_BIT = 6'b01_0100;  // expected background of the read
  localparam logic [5:0] ELEM_WR_BIT = 6'b00_1010;  // background written

endpackage

// File: rtl/sram_march_bist_if.sv
// Bus between the BIST controller and its environment: macro BIST port
// signals plus the start/status/result group.
interface sram_march_bist_if #(
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_DATA_WIDTH = 16
);
  logic                    START;
  logic                    BIST_EN;
  logic                    BIST_MEN;
  logic                    BIST_WEN;
  logic                    BIST_REN;
  logic [P_ADDR_WIDTH-1:0] BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] BIST_DIN;
  logic [P_DATA_WIDTH-1:0] BIST_BM;
  logic [P_DATA_WIDTH-1:0] BIST_DOUT;
  logic                    BUSY;
  logic                    DONE;
  logic                    FAIL;
  logic [2:0]              FAIL_ELEM;
  logic [P_ADDR_WIDTH-1:0] FAIL_ADDR;
  logic [P_DATA_WIDTH-1:0] FAIL_BITS;

  // Controller side.
  modport master (
    input  START, BIST_DOUT,
    output BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM,
    output BUSY, DONE, FAIL, FAIL_ELEM, FAIL_ADDR, FAIL_BITS
  );

  // Environment side: macro plus whoever launches the test.
  modport slave (
    output START, BIST_DOUT,
    input  BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM,
    input  BUSY, DONE, FAIL, FAIL_ELEM, FAIL_ADDR, FAIL_BITS
  );
endinterface

// File: rtl/sram_bist_cmp.sv
// One-stage read compare pipeline with sticky fail flag and first-failure
// capture. A read issued at edge k is compared against DOUT at edge k+1.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    rd_issue,
  input  logic [P_DATA_WIDTH-1:0] rd_exp,
  input  elem_t                   rd_elem,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr,
  input  logic [P_DATA_WIDTH-1:0] dout,
  output logic                    fail,
  output elem_t                   fail_elem,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [P_DATA_WIDTH-1:0] fail_bits
);

  logic                    pipe_vld;
  logic [P_DATA_WIDTH-1:0] pipe_exp;
  elem_t                   pipe_elem;
  logic [P_ADDR_WIDTH-1:0] pipe_addr;
  logic [P_DATA_WIDTH-1:0] diff;

  assign diff = dout ^ pipe_exp;

  // Register the issued read, then compare and capture only the first mismatch.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst || clear) begin
      pipe_vld  <= 1'b0;
      pipe_exp  <= '0;
      pipe_elem <= E0;
      pipe_addr <= '0;
      fail      <= 1'b0;
      fail_elem <= E0;
      fail_addr <= '0;
      fail_bits <= '0;
    end else begin
      pipe_vld  <= rd_issue;
      pipe_exp  <= rd_exp;
      pipe_elem <= rd_elem;
      pipe_addr <= rd_addr;
      if (pipe_vld && (diff != '0) && !fail) begin
        fail      <= 1'b1;
        fail_elem <= pipe_elem;
        fail_addr <= pipe_addr;
        fail_bits <= diff;
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for one BIST port of a 2-port SRAM macro.
// Issues one op per cycle over 10*N cycles, then drains one cycle for the
// last compare and parks in DONE with the results.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_DATA_WIDTH = 16
) (
  input  logic               BIST_CLK,
  input  logic               BIST_RST,
  sram_march_bist_if.master  bus
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                  state, state_nxt;
  elem_t                   elem, elem_nxt;
  logic [P_ADDR_WIDTH-1:0] addr, addr_nxt, addr_last;
  logic                    phase, phase_nxt;   // 0: first op of the address, 1: trailing write
  logic                    start_ok;
  logic                    op_rd;
  logic                    op_wr;

  // Sequencer state, element, address and phase registers.
  always_ff @(posedge BIST_CLK) begin
    if (BIST_RST) begin
      state <= ST_IDLE;
      elem  <= E0;
      addr  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
      addr  <= addr_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state, counter stepping and op decode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    elem_nxt  = elem;
    addr_nxt  = addr;
    phase_nxt = phase;
    start_ok  = 1'b0;
    op_rd     = 1'b0;
    op_wr     = 1'b0;
    addr_last = ELEM_DOWN[elem] ? '0 : ADDR_MAX;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          start_ok  = 1'b1;
          state_nxt = ST_RUN;
          elem_nxt  = E0;
          addr_nxt  = '0;
          phase_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        op_rd = ELEM_HAS_RD[elem] && !phase;
        op_wr = !op_rd;
        if (op_rd && ELEM_HAS_WR[elem]) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (addr == addr_last) begin
            if (elem == E5) begin
              state_nxt = ST_DRAIN;
            end else begin
              elem_nxt = elem + 3'd1;
              addr_nxt = ELEM_DOWN[elem_nxt] ? ADDR_MAX : '0;
            end
          end else begin
            addr_nxt = ELEM_DOWN[elem] ? addr - 1'b1 : addr + 1'b1;
          end
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign bus.BIST_EN   = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.BUSY      = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.DONE      = (state == ST_DONE);
  assign bus.BIST_MEN  = op_rd | op_wr;
  assign bus.BIST_WEN  = op_wr;
  assign bus.BIST_REN  = op_rd;
  assign bus.BIST_ADDR = (op_rd | op_wr) ? addr : '0;
  assign bus.BIST_DIN  = {P_DATA_WIDTH{op_wr & ELEM_WR_BIT[elem]}};
  assign bus.BIST_BM   = '1;

  sram_bist_cmp #(
    .P_ADDR_WIDTH(P_ADDR_WIDTH),
    .P_DATA_WIDTH(P_DATA_WIDTH)
  ) u_cmp (
    .clk       (BIST_CLK),
    .rst       (BIST_RST),
    .clear     (start_ok),
    .rd_issue  (op_rd),
    .rd_exp    ({P_DATA_WIDTH{ELEM_RD_BIT[elem]}}),
    .rd_elem   (elem),
    .rd_addr   (addr),
    .dout      (bus.BIST_DOUT),
    .fail      (bus.FAIL),
    .fail_elem (bus.FAIL_ELEM),
    .fail_addr (bus.FAIL_ADDR),
    .fail_bits (bus.FAIL_BITS)
  );

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist: a behavioural macro with injectable
// faults, a march-table reference model, and a monitor that checks every
// issued op and every DONE result against queued expectations.
`timescale 1ns/1ps
module tb_sram_march_bist;

  localparam int AW      = 10;
  localparam int DW      = 16;
  localparam int N       = 1 << AW;
  localparam int AWS     = 2;
  localparam int NS      = 1 << AWS;
  localparam int ALIAS_A = 'h200;

  typedef struct { bit we; int addr; logic [DW-1:0] data; int elem; } op_t;
  typedef struct { bit fail; int elem; int addr; logic [DW-1:0] bits; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_march_bist_if #(.P_ADDR_WIDTH(AW),  .P_DATA_WIDTH(DW)) bus  ();
  sram_march_bist_if #(.P_ADDR_WIDTH(AWS), .P_DATA_WIDTH(DW)) sbus ();

  sram_march_bist #(.P_ADDR_WIDTH(AW),  .P_DATA_WIDTH(DW)) dut   (.BIST_CLK(clk), .BIST_RST(rst), .bus(bus));
  sram_march_bist #(.P_ADDR_WIDTH(AWS), .P_DATA_WIDTH(DW)) dut_s (.BIST_CLK(clk), .BIST_RST(rst), .bus(sbus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input bit ok, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // ---------------- fault model (0 none, 1 stuck bit, 2 address alias) ----
  int fault_kind = 0;
  int f_addr     = 0;
  int f_bit      = 0;
  bit f_val      = 1'b0;

  function automatic int dec(input int a);
    return (fault_kind == 2 && a == ALIAS_A) ? 0 : a;
  endfunction

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] d, input int a);
    logic [DW-1:0] m;
    m = '0;
    m[f_bit] = 1'b1;
    if (fault_kind == 1 && a == f_addr) return f_val ? (d | m) : (d & ~m);
    return d;
  endfunction

  // ---------------- behavioural macros -------------------------------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] dout_q = '0;
  always @(posedge clk) begin
    if (bus.BIST_MEN && bus.BIST_WEN) mem[dec(int'(bus.BIST_ADDR))] <= bus.BIST_DIN;
    if (bus.BIST_MEN && bus.BIST_REN)
      dout_q <= rd_fault(mem[dec(int'(bus.BIST_ADDR))], int'(bus.BIST_ADDR));
  end
  assign bus.BIST_DOUT = dout_q;

  logic [DW-1:0] smem [NS];
  logic [DW-1:0] sdout_q = '0;
  always @(posedge clk) begin
    if (sbus.BIST_MEN && sbus.BIST_WEN) smem[sbus.BIST_ADDR] <= sbus.BIST_DIN;
    if (sbus.BIST_MEN && sbus.BIST_REN) sdout_q <= smem[sbus.BIST_ADDR];
  end
  assign sbus.BIST_DOUT = sdout_q;

  // ---------------- reference model ----------------------------------------
  // March C- written as text: direction, then op/background pairs.
  function automatic void gen_march(input int n, output op_t q[$]);
    string desc [6];
    string s;
    op_t   o;
    int    a;
    desc = '{"U w0", "U r0 w1", "U r1 w0", "D r0 w1", "D r1 w0", "U r0"};
    q = {};
    for (int e = 0; e < 6; e++) begin
      s = desc[e];
      for (int i = 0; i < n; i++) begin
        a = (s[0] == "D") ? n - 1 - i : i;
        for (int c = 2; c < s.len(); c += 3) begin
          o.we   = (s[c] == "w");
          o.addr = a;
          o.data = (s[c+1] == "1") ? '1 : '0;
          o.elem = e;
          q.push_back(o);
        end
      end
    end
  endfunction

  // Replays the op list on an ideal array with the current fault applied.
  function automatic res_t model_run(input op_t q[$]);
    logic [DW-1:0] m [];
    logic [DW-1:0] got;
    res_t r;
    m = new[N];
    foreach (m[i]) m[i] = '0;
    r.fail = 1'b0; r.elem = 0; r.addr = 0; r.bits = '0;
    foreach (q[i]) begin
      if (q[i].we) m[dec(q[i].addr)] = q[i].data;
      else begin
        got = rd_fault(m[dec(q[i].addr)], q[i].addr);
        if (got !== q[i].data && !r.fail) begin
          r.fail = 1'b1; r.elem = q[i].elem; r.addr = q[i].addr; r.bits = got ^ q[i].data;
        end
      end
    end
    return r;
  endfunction

  function automatic bit op_match(input op_t o, input bit en, input bit wen, input bit ren,
                                  input int addr, input logic [DW-1:0] din, input logic [DW-1:0] bm);
    return en && (wen == o.we) && (ren == !o.we) && (addr == o.addr) &&
           (bm == '1) && (!o.we || din == o.data);
  endfunction

  // ---------------- scoreboard ----------------------------------------------
  op_t  exp_ops [$];
  res_t exp_res [$];
  op_t  sexp    [$];
  int   op_cnt  = 0;
  int   busy_cnt = 0;
  res_t last_res;

  // Monitor for the full-size instance.
  initial begin
    op_t  o;
    res_t r;
    bit   prev_en, prev_men, prev_busy, prev_done;
    prev_en = 0; prev_men = 0; prev_busy = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        op_cnt = 0; busy_cnt = 0;
        prev_en = 0; prev_men = 0; prev_busy = 0; prev_done = 0;
      end else begin
        if (bus.BIST_MEN) begin
          op_cnt++;
          if (exp_ops.size() == 0) begin
            check("op_unexpected", 1'b0, $sformatf("op at addr %0h with empty queue", bus.BIST_ADDR));
          end else begin
            o = exp_ops.pop_front();
            check("op", op_match(o, bus.BIST_EN, bus.BIST_WEN, bus.BIST_REN, int'(bus.BIST_ADDR),
                                 bus.BIST_DIN, bus.BIST_BM),
                  $sformatf("got en=%0b we=%0b re=%0b a=%0h d=%h bm=%h want we=%0b a=%0h d=%h (#%0d)",
                            bus.BIST_EN, bus.BIST_WEN, bus.BIST_REN, bus.BIST_ADDR, bus.BIST_DIN,
                            bus.BIST_BM, o.we, o.addr, o.data, op_cnt));
          end
        end
        if (bus.BUSY) busy_cnt++;
        if (bus.DONE && !prev_done) begin
          check("done_busy_excl", !bus.BUSY && prev_busy,
                $sformatf("busy=%0b prev_busy=%0b", bus.BUSY, prev_busy));
          check("drain_cycle", prev_en && !prev_men,
                $sformatf("prev en=%0b men=%0b want 1/0", prev_en, prev_men));
          check("latency", busy_cnt == 10*N + 1, $sformatf("busy cycles=%0d want %0d", busy_cnt, 10*N + 1));
          check("op_count", op_cnt == 10*N, $sformatf("ops=%0d want %0d", op_cnt, 10*N));
          if (exp_res.size() == 0) begin
            check("result_unexpected", 1'b0, "DONE with no expected result queued");
          end else begin
            r = exp_res.pop_front();
            check("result", bus.FAIL == r.fail && int'(bus.FAIL_ELEM) == r.elem &&
                            int'(bus.FAIL_ADDR) == r.addr && bus.FAIL_BITS == r.bits,
                  $sformatf("got fail=%0b elem=%0d addr=%0h bits=%h want fail=%0b elem=%0d addr=%0h bits=%h",
                            bus.FAIL, bus.FAIL_ELEM, bus.FAIL_ADDR, bus.FAIL_BITS,
                            r.fail, r.elem, r.addr, r.bits));
          end
          busy_cnt = 0;
          op_cnt   = 0;
        end
        prev_en = bus.BIST_EN; prev_men = bus.BIST_MEN; prev_busy = bus.BUSY; prev_done = bus.DONE;
      end
    end
  end

  // Monitor for the 4-word instance: exact op trace.
  initial begin
    op_t o;
    forever begin
      @(negedge clk);
      if (!rst && sbus.BIST_MEN) begin
        if (sexp.size() == 0) begin
          check("small_op_unexpected", 1'b0, $sformatf("op at addr %0h", sbus.BIST_ADDR));
        end else begin
          o = sexp.pop_front();
          check("small_op", op_match(o, sbus.BIST_EN, sbus.BIST_WEN, sbus.BIST_REN, int'(sbus.BIST_ADDR),
                                     sbus.BIST_DIN, sbus.BIST_BM),
                $sformatf("got we=%0b re=%0b a=%0h d=%h want we=%0b a=%0h d=%h",
                          sbus.BIST_WEN, sbus.BIST_REN, sbus.BIST_ADDR, sbus.BIST_DIN, o.we, o.addr, o.data));
        end
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    op_t q[$];
    gen_march(N, q);
    last_res = model_run(q);
    foreach (q[i]) exp_ops.push_back(q[i]);
    exp_res.push_back(last_res);
  endtask

  task automatic launch(input bit hold);
    push_exp();
    bus.START = 1'b1;
    tick();
    if (!hold) bus.START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.DONE && n < 11*N) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, bus.DONE, $sformatf("DONE=%0b after %0d cycles", bus.DONE, n));
  endtask

  initial begin
    op_t q[$];
    int  n;
    bus.START  = 1'b0;
    sbus.START = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    check("rst_ctrl", !bus.BIST_EN && !bus.BIST_MEN && !bus.BIST_WEN && !bus.BIST_REN &&
                      !bus.BUSY && !bus.DONE,
          $sformatf("en=%0b men=%0b wen=%0b ren=%0b busy=%0b done=%0b", bus.BIST_EN, bus.BIST_MEN,
                    bus.BIST_WEN, bus.BIST_REN, bus.BUSY, bus.DONE));
    check("rst_data", bus.BIST_ADDR == '0 && bus.BIST_DIN == '0 && bus.BIST_BM == '1,
          $sformatf("addr=%0h din=%h bm=%h", bus.BIST_ADDR, bus.BIST_DIN, bus.BIST_BM));
    check("rst_result", !bus.FAIL && bus.FAIL_ELEM == '0 && bus.FAIL_ADDR == '0 && bus.FAIL_BITS == '0,
          $sformatf("fail=%0b elem=%0d addr=%0h bits=%h", bus.FAIL, bus.FAIL_ELEM, bus.FAIL_ADDR, bus.FAIL_BITS));
    rst = 1'b0;
    tick();

    // 4-word instance: 40-op trace, then drain and DONE.
    gen_march(NS, q);
    foreach (q[i]) sexp.push_back(q[i]);
    sbus.START = 1'b1;
    tick();
    sbus.START = 1'b0;

    // Fault-free full run after a random idle gap.
    fault_kind = 0;
    repeat ($urandom_range(0, 7)) tick();
    launch(1'b0);
    wait_done("clean");
    check("small_done", sbus.DONE && !sbus.FAIL && sexp.size() == 0,
          $sformatf("done=%0b fail=%0b left=%0d", sbus.DONE, sbus.FAIL, sexp.size()));
    repeat ($urandom_range(2, 6)) tick();
    check("done_hold", bus.DONE && !bus.BUSY && bus.FAIL == last_res.fail,
          $sformatf("done=%0b busy=%0b fail=%0b", bus.DONE, bus.BUSY, bus.FAIL));

    // Bit 3 stuck-at-1 at 0x155.
    fault_kind = 1; f_addr = 'h155; f_bit = 3; f_val = 1'b1;
    launch(1'b0);
    wait_done("stuck");

    // Address 0x200 decodes onto 0x000.
    fault_kind = 2;
    launch(1'b0);
    wait_done("alias");

    // Reset at op 500, then a clean restart from E0 address 0.
    fault_kind = 0;
    launch(1'b0);
    n = 0;
    while (op_cnt < 500 && n < 2*N) begin
      tick();
      n++;
    end
    check("reach_op500", op_cnt == 500, $sformatf("ops=%0d", op_cnt));
    rst = 1'b1;
    tick();
    check("abort_idle", !bus.BIST_EN && !bus.BIST_MEN && !bus.FAIL && !bus.BUSY && !bus.DONE,
          $sformatf("en=%0b men=%0b fail=%0b busy=%0b done=%0b", bus.BIST_EN, bus.BIST_MEN,
                    bus.FAIL, bus.BUSY, bus.DONE));
    exp_ops.delete();
    exp_res.delete();
    tick();
    rst = 1'b0;
    tick();
    launch(1'b0);
    wait_done("restart");

    // START held high: random stuck fault run, then an immediate clean run.
    fault_kind = 1; f_addr = $urandom_range(0, N-1); f_bit = $urandom_range(0, DW-1);
    f_val = 1'($urandom_range(0, 1));
    launch(1'b1);
    wait_done("held_first");
    fault_kind = 0;
    push_exp();
    tick();
    check("held_restart", bus.BUSY && !bus.DONE, $sformatf("busy=%0b done=%0b", bus.BUSY, bus.DONE));
    wait_done("held_second");
    bus.START = 1'b0;
    tick();
    check("second_clean", bus.DONE && !bus.FAIL, $sformatf("done=%0b fail=%0b", bus.DONE, bus.FAIL));
    check("sb_drained", exp_ops.size() == 0 && exp_res.size() == 0,
          $sformatf("ops left=%0d results left=%0d", exp_ops.size(), exp_res.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
